// File: rtl/led_pkg.sv
// Constants shared by the LED frame loader and the LED driver top:
// command encodings, loader FSM states and the channel-byte count helper.
package led_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PIXEL   = 3'd1,
    ST_DISCARD = 3'd2,
    ST_BRIGHT  = 3'd3,
    ST_COMMIT  = 3'd4
  } state_t;

  localparam logic [7:0] CMD_BRIGHT  = 8'h80;
  // A command byte with none of these bits set is a pixel write command.
  localparam logic [7:0] CMD_WR_MASK = 8'h80;

  function automatic int chan_bytes(input int led_cnt, input int channels);
    return led_cnt * channels;
  endfunction

endpackage

// File: rtl/led_scale.sv
// Registered brightness scaler: pix_p1 = (pix_p0 * (bright + 1)) >> COEF_W,
// one cycle after pix_p0, with the valid flag travelling alongside.
module led_scale #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vld_p0,
  input  logic [DATA_W-1:0] pix_p0,
  input  logic [COEF_W-1:0] bright,
  output logic              vld_p1,
  output logic [DATA_W-1:0] pix_p1
);

  localparam int PW = DATA_W + COEF_W;

  // (2^D-1)*2^C still fits in D+C bits, so the product never overflows.
  function automatic logic [DATA_W-1:0] scale(input logic [DATA_W-1:0] v,
                                              input logic [COEF_W-1:0] b);
    logic [PW-1:0] prod;
    prod = PW'(v) * (PW'(b) + PW'(1));
    return DATA_W'(prod >> COEF_W);
  endfunction

  // p0 -> p1
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) vld_p1 <= 1'b0;
    else        vld_p1 <= vld_p0;
  end

  always_ff @(posedge clk) begin
    pix_p1 <= scale(pix_p0, bright);
  end

endmodule

// File: rtl/led_frame_ctrl.sv
// Host byte-stream loader: fills a shadow frame, then commits it through the
// brightness scaler into the active frame that feeds the serial LED driver.
module led_frame_ctrl
  import led_pkg::*;
#(
  parameter int LED_CNT       = 3,
  parameter int CHANNELS      = 3,
  parameter int BITPERCHANNEL = 8
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      wr_valid,
  input  logic [7:0]                                wr_data,
  input  logic                                      wr_last,
  output logic                                      wr_ready,
  output logic [LED_CNT*CHANNELS*BITPERCHANNEL-1:0] data,
  output logic                                      busy,
  output logic                                      frame_done,
  output logic                                      err
);

  localparam int CHAN_BYTES = chan_bytes(LED_CNT, CHANNELS);
  localparam int CNT_W      = $clog2(CHAN_BYTES + 1);

  if (BITPERCHANNEL != 8) begin : g_bad_bpc
    $error("led_frame_ctrl: BITPERCHANNEL must be 8");
  end
  if (LED_CNT < 1 || LED_CNT > 128) begin : g_bad_cnt
    $error("led_frame_ctrl: LED_CNT must be 1..128");
  end

  logic [7:0]       shadow [CHAN_BYTES];
  logic [7:0]       active [CHAN_BYTES];
  state_t           state_q, state_d;
  logic [CNT_W-1:0] ptr_q, ptr_d, cnt_q, cnt_d;
  logic [7:0]       bright_q, bright_d;
  logic             shadow_we, err_d, done_d, accept, in_range;
  logic             vld_p0, vld_p1;
  logic [7:0]       pix_p0, pix_p1;

  assign busy     = (state_q == ST_COMMIT);
  assign wr_ready = !busy;
  assign accept   = wr_valid && wr_ready;
  assign in_range = (32'(wr_data[6:0]) < LED_CNT);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    bright_d  = bright_q;
    shadow_we = 1'b0;
    err_d     = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if ((wr_data & CMD_WR_MASK) == 8'h00) begin
            if (!in_range) begin
              err_d   = 1'b1;
              state_d = wr_last ? ST_IDLE : ST_DISCARD;
            end else if (wr_last) begin
              state_d = ST_COMMIT;
              cnt_d   = '0;
            end else begin
              state_d = ST_PIXEL;
              ptr_d   = CNT_W'(32'(wr_data[6:0]) * CHANNELS);
            end
          end else if (wr_data == CMD_BRIGHT) begin
            err_d   = wr_last;
            state_d = wr_last ? ST_IDLE : ST_BRIGHT;
          end else begin
            err_d   = 1'b1;
            state_d = wr_last ? ST_IDLE : ST_DISCARD;
          end
        end
      end
      ST_PIXEL: begin
        if (accept) begin
          shadow_we = 1'b1;
          ptr_d     = (ptr_q == CNT_W'(CHAN_BYTES - 1)) ? '0 : ptr_q + 1'b1;
          if (wr_last) begin
            state_d = ST_COMMIT;
            cnt_d   = '0;
          end
        end
      end
      ST_DISCARD: begin
        if (accept && wr_last) state_d = ST_IDLE;
      end
      ST_BRIGHT: begin
        if (accept) begin
          bright_d = wr_data;
          state_d  = ST_COMMIT;
          cnt_d    = '0;
        end
      end
      ST_COMMIT: begin
        // cnt issues byte cnt into the scaler and retires byte cnt-1.
        if (cnt_q == CNT_W'(CHAN_BYTES)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign vld_p0 = busy && (cnt_q != CNT_W'(CHAN_BYTES));

  always_comb begin
    pix_p0 = 8'h00;
    for (int k = 0; k < CHAN_BYTES; k++) begin
      if (cnt_q == CNT_W'(k)) pix_p0 = shadow[k];
    end
  end

  led_scale #(.DATA_W(8), .COEF_W(8)) u_scale (
    .clk    (clk),
    .reset  (reset),
    .vld_p0 (vld_p0),
    .pix_p0 (pix_p0),
    .bright (bright_q),
    .vld_p1 (vld_p1),
    .pix_p1 (pix_p1)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      cnt_q      <= '0;
      bright_q   <= 8'hFF;
      err        <= 1'b0;
      frame_done <= 1'b0;
      for (int k = 0; k < CHAN_BYTES; k++) begin
        shadow[k] <= 8'h00;
        active[k] <= 8'h00;
      end
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      bright_q   <= bright_d;
      err        <= err_d;
      frame_done <= done_d;
      for (int k = 0; k < CHAN_BYTES; k++) begin
        if (shadow_we && ptr_q == CNT_W'(k)) shadow[k] <= wr_data;
        if (vld_p1 && cnt_q == CNT_W'(k + 1)) active[k] <= pix_p1;
      end
    end
  end

  // The driver shifts data[0] first and wants each channel byte MSB first.
  for (genvar k = 0; k < CHAN_BYTES; k++) begin : g_bus
    assign data[k*8 +: 8] = {<<{active[k]}};
  end

endmodule

// File: tb/tb_led_frame_ctrl.sv
// Scoreboard bench for led_frame_ctrl: directed scenarios plus random
// transactions against a frame-level reference model.
module tb_led_frame_ctrl;

  localparam int LED_CNT  = 3;
  localparam int CHANNELS = 3;
  localparam int N        = LED_CNT * CHANNELS;
  localparam int W        = N * 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         wr_valid, wr_last, wr_ready, busy, frame_done, err;
  logic [7:0]   wr_data;
  logic [W-1:0] data;

  always #5 clk = ~clk;

  led_frame_ctrl #(.LED_CNT(LED_CNT), .CHANNELS(CHANNELS), .BITPERCHANNEL(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .wr_last    (wr_last),
    .wr_ready   (wr_ready),
    .data       (data),
    .busy       (busy),
    .frame_done (frame_done),
    .err        (err)
  );

  typedef struct {
    bit           is_done;
    logic [W-1:0] frame;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   busy_cnt = 0;
  int   m_shadow [N];
  int   m_bright;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: got timeout expected event", name);
  endtask

  // Expected driver bus: scaled value v of byte k lands on data[k*8+(7-i)] = v[i].
  function automatic logic [W-1:0] m_frame();
    logic [W-1:0] f;
    logic [7:0]   v;
    f = '0;
    for (int k = 0; k < N; k++) begin
      v = 8'((m_shadow[k] * (m_bright + 1)) / 256);
      for (int i = 0; i < 8; i++) f[k*8 + (7 - i)] = v[i];
    end
    return f;
  endfunction

  function automatic logic [7:0] act_byte(input int k);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = data[k*8 + (7 - i)];
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N; k++) m_shadow[k] = 0;
    m_bright = 255;
  endtask

  task automatic push_evt(input bit is_done);
    exp_t e;
    e.is_done = is_done;
    e.frame   = is_done ? m_frame() : '0;
    exp_q.push_back(e);
  endtask

  task automatic model_txn(input int b[$]);
    int n;
    n = b.size();
    if (b[0] < 128) begin
      if (b[0] >= LED_CNT) push_evt(1'b0);
      else begin
        for (int j = 1; j < n; j++) m_shadow[(b[0] * CHANNELS + j - 1) % N] = b[j];
        push_evt(1'b1);
      end
    end else if (b[0] == 128) begin
      if (n == 1) push_evt(1'b0);
      else begin
        m_bright = b[1];
        push_evt(1'b1);
      end
    end else begin
      push_evt(1'b0);
    end
  endtask

  task automatic send_byte(input int b, input logic last);
    int guard;
    guard = 0;
    repeat ($urandom_range(0, 2)) @(negedge clk);
    @(negedge clk);
    wr_valid = 1'b1;
    wr_data  = 8'(b);
    wr_last  = last;
    while (!wr_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) fail_now("wr_ready_wait");
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
    wr_last  = 1'b0;
  endtask

  // nolast leaves wr_last clear on the final byte (only meaningful for brightness).
  task automatic send_txn(input int b[$], input bit nolast);
    model_txn(b);
    for (int i = 0; i < b.size(); i++)
      send_byte(b[i], (i == b.size() - 1) && !nolast);
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || busy) && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 1000) fail_now("wait_idle");
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset !== 1'b1) begin
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (err) begin
        if (exp_q.size() == 0) fail_now("unexpected_err");
        else begin
          e = exp_q.pop_front();
          check("event_is_err", W'(e.is_done), W'(0));
        end
      end
      if (frame_done) begin
        if (exp_q.size() == 0) fail_now("unexpected_frame_done");
        else begin
          e = exp_q.pop_front();
          check("event_is_done", W'(e.is_done), W'(1));
          if (e.is_done) begin
            check("frame_data", data, e.frame);
            check("busy_cycles", W'(busy_cnt), W'(N + 1));
          end
        end
        busy_cnt = 0;
      end
    end
  end

  initial begin
    int b[$];
    int t, n, g;
    reset    = 1'b0;
    wr_valid = 1'b0;
    wr_data  = 8'h00;
    wr_last  = 1'b0;
    model_reset();
    #12;
    check("reset_data", data, '0);
    check("reset_wr_ready", W'(wr_ready), W'(1));
    check("reset_busy", W'(busy), W'(0));
    check("reset_frame_done", W'(frame_done), W'(0));
    check("reset_err", W'(err), W'(0));
    @(negedge clk);
    reset = 1'b1;

    b = {8'h00, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80, 8'h90};
    send_txn(b, 1'b0);
    wait_idle();
    check("t1_data_7_0", W'(data[7:0]), W'(8'h08));
    check("t1_byte8", W'(act_byte(8)), W'(8'h90));

    b = {8'h80, 8'h7F};
    send_txn(b, 1'b0);
    wait_idle();
    check("t2_byte0", W'(act_byte(0)), W'(8'h08));
    check("t2_byte8", W'(act_byte(8)), W'(8'h48));

    b = {8'h02, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    send_txn(b, 1'b0);
    wait_idle();
    check("t3_byte6", W'(act_byte(6)), W'(8'h55));
    check("t3_byte0_wrap", W'(act_byte(0)), W'(8'h6E));
    check("t3_byte1_kept", W'(act_byte(1)), W'(8'h10));

    b = {8'h05, 8'h01, 8'h02};
    send_txn(b, 1'b0);
    wait_idle();
    check("t4_frame_kept", data, m_frame());

    b = {8'h80};
    send_txn(b, 1'b0);
    b = {8'h00};
    send_txn(b, 1'b0);
    wait_idle();
    check("t5_bright_kept", W'(act_byte(6)), W'(8'h55));

    // Reset in the fourth COMMIT cycle.
    b = {8'h00};
    send_txn(b, 1'b0);
    g = 0;
    while (!busy && g < 50) begin
      @(negedge clk);
      g++;
    end
    repeat (3) @(negedge clk);
    check("mid_commit_busy", W'(busy), W'(1));
    check("mid_commit_wr_ready", W'(wr_ready), W'(0));
    #2;
    reset = 1'b0;
    exp_q.delete();
    model_reset();
    #1;
    check("async_reset_data", data, '0);
    check("async_reset_wr_ready", W'(wr_ready), W'(1));
    repeat (2) @(negedge clk);
    reset = 1'b1;
    b = {8'h80, 8'hFF};
    send_txn(b, 1'b0);
    b = {8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
    send_txn(b, 1'b0);
    wait_idle();
    check("identity_byte0", W'(act_byte(0)), W'(8'h01));
    check("identity_byte8", W'(act_byte(8)), W'(8'h09));

    repeat (60) begin
      t = $urandom_range(0, 9);
      b = {};
      if (t <= 4) begin
        b.push_back($urandom_range(0, 4));
        n = $urandom_range(0, 12);
        repeat (n) b.push_back($urandom_range(0, 255));
        send_txn(b, 1'b0);
      end else if (t <= 6) begin
        b.push_back(128);
        b.push_back($urandom_range(0, 255));
        send_txn(b, 1'($urandom_range(0, 1)));
      end else if (t == 7) begin
        b.push_back(128);
        send_txn(b, 1'b0);
      end else if (t == 8) begin
        b.push_back($urandom_range(129, 255));
        repeat ($urandom_range(0, 3)) b.push_back($urandom_range(0, 255));
        send_txn(b, 1'b0);
      end else begin
        b.push_back($urandom_range(LED_CNT, 127));
        repeat ($urandom_range(0, 3)) b.push_back($urandom_range(0, 255));
        send_txn(b, 1'b0);
      end
      if ($urandom_range(0, 3) == 0) wait_idle();
    end
    wait_idle();
    check("final_queue_empty", W'(exp_q.size()), W'(0));
    check("final_frame", data, m_frame());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
